// File: rtl/gelu_pkg.sv
// Shared types and sizing helpers for the GELU operator output side.
// Defaults match the operator wrappers' input_shape.
package gelu_pkg;

    localparam int GELU_NUM_D     = 128;
    localparam int DIMENTION_D    = 64;
    localparam int OUTPUT_WIDTH_D = 8;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    function automatic int row_w(input int ow, input int dim);
        return ow * dim;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W = row_w(OUTPUT_WIDTH_D, DIMENTION_D);
    localparam int IDX_W = idx_w(GELU_NUM_D);

endpackage

// File: rtl/gelu_frame_buf.sv
// Whole-frame capture register with a single load enable.
// Rows are read back through a mux indexed by the row counter.
module gelu_frame_buf
    import gelu_pkg::*;
#(
    parameter int GELU_NUM = GELU_NUM_D,
    parameter int ROW_W    = row_w(OUTPUT_WIDTH_D, DIMENTION_D),
    parameter int IDX_W    = idx_w(GELU_NUM_D)
) (
    input  logic                      clk_p,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [GELU_NUM*ROW_W-1:0] frame,
    input  logic [IDX_W-1:0]          idx,
    output logic [ROW_W-1:0]          row
);

    logic [ROW_W-1:0] mem [GELU_NUM];

    // Capture every row at once so the buffer is never partially updated
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GELU_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < GELU_NUM; i++) begin
                mem[i] <= frame[i*ROW_W +: ROW_W];
            end
        end
    end

    assign row = mem[idx];

endmodule

// File: rtl/gelu_row_streamer.sv
// Captures one GELU output frame on a falling frame-valid edge and
// replays it row by row over an active-low valid/ready handshake.
module gelu_row_streamer
    import gelu_pkg::*;
#(
    parameter int GELU_NUM     = GELU_NUM_D,
    parameter int DIMENTION    = DIMENTION_D,
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_D,
    localparam int ROW_W       = row_w(OUTPUT_WIDTH, DIMENTION),
    localparam int IDX_W       = idx_w(GELU_NUM)
) (
    input  logic                      clk_p,
    input  logic                      rst_n,
    input  logic [GELU_NUM*ROW_W-1:0] gelu,
    input  logic                      gelu_valid_n,
    output logic                      in_ready,
    output logic [ROW_W-1:0]          row_data,
    output logic                      row_valid_n,
    input  logic                      row_ready_n,
    output logic [IDX_W-1:0]          row_idx,
    output logic                      row_last,
    output logic                      frame_done_n,
    output logic                      overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(GELU_NUM - 1);

    state_t state;
    logic   valid_d;
    logic   start;
    logic   xfer;
    logic   last_xfer;
    logic   load;

    assign start     = !gelu_valid_n && valid_d;
    assign xfer      = !row_valid_n && !row_ready_n;
    assign last_xfer = (state == STREAM) && xfer && (row_idx == LAST);
    assign in_ready  = (state == IDLE) || last_xfer;
    assign load      = start && in_ready;

    gelu_frame_buf #(
        .GELU_NUM (GELU_NUM),
        .ROW_W    (ROW_W),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .load  (load),
        .frame (gelu),
        .idx   (row_idx),
        .row   (row_data)
    );

    // Frame FSM: edge detect, row counter and handshake flags
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid_d      <= 1'b1;
            row_idx      <= '0;
            row_valid_n  <= 1'b1;
            row_last     <= 1'b0;
            frame_done_n <= 1'b1;
            overrun      <= 1'b0;
        end else begin
            valid_d      <= gelu_valid_n;
            frame_done_n <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= STREAM;
                        row_idx     <= '0;
                        row_valid_n <= 1'b0;
                        row_last    <= (GELU_NUM == 1);
                    end
                end
                STREAM: begin
                    if (last_xfer) begin
                        frame_done_n <= 1'b0;
                        row_idx      <= '0;
                        if (start) begin
                            row_last <= (GELU_NUM == 1);
                        end else begin
                            state       <= IDLE;
                            row_valid_n <= 1'b1;
                            row_last    <= 1'b0;
                        end
                    end else if (xfer) begin
                        row_idx  <= row_idx + IDX_W'(1);
                        row_last <= ((row_idx + IDX_W'(1)) == LAST);
                    end
                    // A frame arriving mid-stream is dropped, not queued
                    if (start && !last_xfer) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gelu_row_streamer.sv
// Scoreboard bench for gelu_row_streamer (4 rows x 2 elems x 8 bits).
// Expected rows are queued at frame acceptance and popped on transfer.
module tb_gelu_row_streamer;

    localparam int GN = 4;
    localparam int RW = 16;
    localparam logic [63:0] FRAME_A = 64'h0807_0605_0403_0201;
    localparam logic [63:0] FRAME_B = 64'h4444_3333_2222_1111;
    localparam logic [63:0] FRAME_F = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [RW-1:0] data;
        logic [1:0]    idx;
    } ent_t;

    logic          clk_p;
    logic          rst_n;
    logic [63:0]   gelu;
    logic          gelu_valid_n;
    logic          in_ready;
    logic [RW-1:0] row_data;
    logic          row_valid_n;
    logic          row_ready_n;
    logic [1:0]    row_idx;
    logic          row_last;
    logic          frame_done_n;
    logic          overrun;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_xfer = 0;
    ent_t sb[$];
    logic vd_m = 1'b1;
    logic ov_m = 1'b0;
    logic done_m = 1'b0;

    gelu_row_streamer #(
        .GELU_NUM     (GN),
        .DIMENTION    (2),
        .OUTPUT_WIDTH (8)
    ) dut (
        .clk_p        (clk_p),
        .rst_n        (rst_n),
        .gelu         (gelu),
        .gelu_valid_n (gelu_valid_n),
        .in_ready     (in_ready),
        .row_data     (row_data),
        .row_valid_n  (row_valid_n),
        .row_ready_n  (row_ready_n),
        .row_idx      (row_idx),
        .row_last     (row_last),
        .frame_done_n (frame_done_n),
        .overrun      (overrun)
    );

    initial begin
        clk_p = 1'b0;
        forever #5 clk_p = ~clk_p;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_p);
        #1;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle
    always @(negedge clk_p) begin
        logic streaming;
        logic xfer_m;
        logic last_m;
        logic start_m;
        logic accept_m;
        if (!rst_n) begin
            sb.delete();
            vd_m   = 1'b1;
            ov_m   = 1'b0;
            done_m = 1'b0;
            check("rst_valid_n", 64'(row_valid_n), 64'd1);
            check("rst_idx", 64'(row_idx), 64'd0);
            check("rst_overrun", 64'(overrun), 64'd0);
            check("rst_done_n", 64'(frame_done_n), 64'd1);
        end else begin
            streaming = (sb.size() > 0);
            check("valid_n", 64'(row_valid_n), 64'(!streaming));
            if (streaming) begin
                check("row_data", 64'(row_data), 64'(sb[0].data));
                check("row_idx", 64'(row_idx), 64'(sb[0].idx));
                check("row_last", 64'(row_last),
                      64'(sb[0].idx == 2'(GN - 1)));
            end else begin
                check("row_last_idle", 64'(row_last), 64'd0);
            end
            check("done_n", 64'(frame_done_n), 64'(!done_m));
            check("overrun", 64'(overrun), 64'(ov_m));
            xfer_m   = streaming && !row_ready_n;
            last_m   = xfer_m && (sb.size() == 1);
            start_m  = !gelu_valid_n && vd_m;
            accept_m = !streaming || last_m;
            check("in_ready", 64'(in_ready), 64'(accept_m));
            if (xfer_m) begin
                void'(sb.pop_front());
                n_xfer++;
            end
            done_m = last_m;
            if (start_m) begin
                if (accept_m) begin
                    for (int i = 0; i < GN; i++) begin
                        sb.push_back('{data: gelu[i*RW +: RW],
                                       idx: 2'(i)});
                    end
                end else begin
                    ov_m = 1'b1;
                end
            end
            vd_m = gelu_valid_n;
        end
    end

    task automatic pulse(input logic [63:0] f);
        gelu         = f;
        gelu_valid_n = 1'b0;
        tick(1);
        gelu_valid_n = 1'b1;
        gelu         = FRAME_A;
    endtask

    initial begin
        rst_n        = 1'b0;
        gelu         = FRAME_A;
        gelu_valid_n = 1'b1;
        row_ready_n  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Basic single-pulse frame at full rate
        n_xfer = 0;
        pulse(FRAME_A);
        tick(8);
        check("basic_xfers", 64'(n_xfer), 64'd4);

        // Stall three cycles while row 1 is presented
        n_xfer = 0;
        pulse(FRAME_A);
        tick(1);
        row_ready_n = 1'b1;
        tick(3);
        row_ready_n = 1'b0;
        tick(6);
        check("bp_xfers", 64'(n_xfer), 64'd4);

        // Held-low frame valid yields a single frame
        n_xfer = 0;
        gelu_valid_n = 1'b0;
        tick(20);
        gelu_valid_n = 1'b1;
        tick(4);
        check("level_xfers", 64'(n_xfer), 64'd4);
        check("level_in_ready", 64'(in_ready), 64'd1);
        check("level_overrun", 64'(overrun), 64'd0);

        // Second edge mid-frame is dropped and flagged
        n_xfer = 0;
        pulse(FRAME_A);
        tick(2);
        pulse(FRAME_F);
        tick(6);
        check("ovr_xfers", 64'(n_xfer), 64'd4);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_idle", 64'(in_ready), 64'd1);

        // Reset in the middle of a frame aborts it
        pulse(FRAME_A);
        tick(2);
        check("pre_rst_idx", 64'(row_idx), 64'd2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_xfer = 0;
        tick(6);
        check("post_rst_xfers", 64'(n_xfer), 64'd0);

        // New frame accepted on the final row's transfer
        n_xfer = 0;
        pulse(FRAME_A);
        tick(3);
        pulse(FRAME_B);
        check("b2b_data", 64'(row_data), 64'h1111);
        check("b2b_idx", 64'(row_idx), 64'd0);
        check("b2b_valid_n", 64'(row_valid_n), 64'd0);
        check("b2b_overrun", 64'(overrun), 64'd0);
        tick(8);
        check("b2b_xfers", 64'(n_xfer), 64'd8);
        check("b2b_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
